alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port cmd_valid, input, 1, command present.
REQ-004 SHALL have port cmd_ready, output, 1, sequencer accepts a command this cycle.
REQ-005 SHALL have port cmd_ld, input, 1, 1 = load immediate, 0 = ALU operation.
REQ-006 SHALL have port cmd_op, input, 3, ALU select code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 inc a, 111 dec a).
REQ-007 SHALL have ports cmd_rd, cmd_ra, cmd_rb, input, 2 each, destination and source register indices.
REQ-008 SHALL have port cmd_imm, input, 4, immediate for loads.
REQ-009 SHALL have ports alu_a, alu_b (output, 4) and alu_s (output, 3), operands and select to the combinational 4-bit ALU.
REQ-010 SHALL have ports alu_result (input, 4), alu_carry, alu_zero, alu_parity (input, 1 each), returned from the ALU in the same cycle.
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), response handshake.
REQ-012 SHALL have ports rsp_data (output, 4) and rsp_flags (output, 3, {carry, zero, parity}).
REQ-013 SHALL have port op_count, output, 8, completed-response count.

Function
REQ-014 SHALL hold four 4-bit registers r0..r3.
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-016 SHALL accept a command on cmd_valid & cmd_ready.
REQ-017 On an accepted load, SHALL write cmd_imm to r[cmd_rd] at that edge, stay in IDLE, and issue no response.
REQ-018 On an accepted ALU op, SHALL latch cmd_op, cmd_rd, r[cmd_ra], r[cmd_rb] and go to EXEC; later register writes do not alter latched operands.
REQ-019 In EXEC (exactly one cycle), SHALL drive alu_a, alu_b, alu_s from the latched values; in other states they are 0.
REQ-020 At the end of EXEC, SHALL write alu_result to r[rd], capture rsp_data = alu_result and rsp_flags = {alu_carry when op==000 else 0, alu_zero, alu_parity}, then go to RESP.
REQ-021 In RESP, rsp_valid = 1; rsp_data and rsp_flags held stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-022 Latency: op accepted at edge N; EXEC during cycle N+1; rsp_valid high from cycle N+2; earliest next accept is the cycle after the handshake (at most one op in flight).
REQ-023 rd equal to ra or rb is legal; the result overwrites the register after its operands are read.
REQ-024 op_count SHALL increment by 1 on each response handshake and wrap 255 -> 0; loads do not count.
REQ-025 cmd_* inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.

Reset
REQ-026 While rst_n = 0 at a clock edge: state = IDLE, r0..r3 = 0, latches = 0, rsp_valid = 0, rsp_data = 0, rsp_flags = 0, op_count = 0, alu_a/alu_b/alu_s = 0.
REQ-027 Reset in EXEC or RESP SHALL abandon the op: no register write, no response, and no op_count increment; cmd_ready = 1 on the first cycle after release.

Verification
REQ-028 Load r0=9, r1=8; add (op 000) rd=2, ra=0, rb=1 -> rsp_data=1, rsp_flags=101, r2=1, op_count=1.
REQ-029 Load r0=3, r1=5; sub (op 001) rd=3 -> rsp_data=14, rsp_flags=001 (carry forced 0), r3=14.
REQ-030 xor (op 100) rd=0 with r0=r1=6 -> rsp_data=0, rsp_flags=010; r0=0.
REQ-031 Hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid stays 1, data and flags stable, cmd_ready=0, and a cmd_valid pulse is dropped.
REQ-032 Assert rst_n=0 for one cycle during EXEC of an add into r2 -> r2=0, rsp_valid never rises, and op_count=0.
REQ-033 Run 256 back-to-back ops with rsp_ready=1 -> op_count reads 255 after the 255th handshake and 0 after the 256th.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle for the ALU op sequencer.
// master issues commands and consumes responses; slave is the sequencer.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ld;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic [3:0] cmd_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_flags;

  modport master (
    output cmd_valid, cmd_ld, cmd_op,
    output cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_flags,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_ld, cmd_op,
    input  cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_flags,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Four-register sequencer driving an external 4-bit combinational ALU.
// One op in flight: IDLE accepts, EXEC drives the ALU, RESP holds result.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_parity,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] rf [4];
  logic [2:0] lat_op;
  logic [1:0] lat_rd;
  logic [3:0] lat_a;
  logic [3:0] lat_b;
  logic [3:0] data_q;
  logic [2:0] flags_q;
  logic       accept;
  logic       in_exec;
  logic       hs;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;

  assign accept  = bus.cmd_valid & bus.cmd_ready;
  assign in_exec = (state == EXEC);
  assign hs      = bus.rsp_valid & bus.rsp_ready;

  assign alu_a = in_exec ? lat_a  : 4'd0;
  assign alu_b = in_exec ? lat_b  : 4'd0;
  assign alu_s = in_exec ? lat_op : 3'd0;

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept && !bus.cmd_ld)
          state_nx = EXEC;
      end
      (state == EXEC): state_nx = RESP;
      (state == RESP): begin
        if (bus.rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_op   <= '0;
      lat_rd   <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      data_q   <= '0;
      flags_q  <= '0;
      op_count <= '0;
      for (int i = 0; i < 4; i++)
        rf[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept && bus.cmd_ld)
        rf[bus.cmd_rd] <= bus.cmd_imm;
      // operands captured by value so later writes cannot disturb them
      if (accept && !bus.cmd_ld) begin
        lat_op <= bus.cmd_op;
        lat_rd <= bus.cmd_rd;
        lat_a  <= rf[bus.cmd_ra];
        lat_b  <= rf[bus.cmd_rb];
      end
      if (in_exec) begin
        rf[lat_rd] <= alu_result;
        data_q     <= alu_result;
        flags_q    <= {(lat_op == 3'b000) & alu_carry,
                       alu_zero, alu_parity};
      end
      if (hs)
        op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, stall/reset
// sequences and a randomized run against a behavioural model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus();

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_parity;
  logic [7:0] op_count;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .alu_parity (alu_parity),
    .op_count   (op_count)
  );

  // external ALU; carry also reports borrow so the forcing is exercised
  always_comb begin
    logic [4:0] w;
    w = '0;
    case (alu_s)
      3'd0: w = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: w = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: w = {1'b0, alu_a & alu_b};
      3'd3: w = {1'b0, alu_a | alu_b};
      3'd4: w = {1'b0, alu_a ^ alu_b};
      3'd5: w = {1'b0, ~alu_a};
      3'd6: w = {1'b0, alu_a} + 5'd1;
      default: w = {1'b0, alu_a} - 5'd1;
    endcase
    alu_result = w[3:0];
    alu_carry  = w[4];
    alu_zero   = (w[3:0] == 4'd0);
    alu_parity = ^w[3:0];
  end

  int pass_n = 0;
  int total_n = 0;
  int m_rf [4];
  int m_cnt;

  typedef struct {
    int ld;
    int op;
    int rd;
    int ra;
    int rb;
    int imm;
    int ed;
    int ef;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp)
      pass_n++;
    else
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int d, output int f);
    int r;
    int c;
    c = 0;
    case (op)
      0: begin
        r = a + b;
        c = (r > 15) ? 1 : 0;
      end
      1: r = a - b + 16;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: r = a + 1;
      default: r = a + 15;
    endcase
    d = r % 16;
    f = c * 4 + ((d == 0) ? 2 : 0) + ($countones(d) % 2);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      m_rf[i] = 0;
    m_cnt = 0;
  endtask

  task automatic do_ld(input int rd, input int imm);
    chk("ld_ready", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_ld    = 1'b1;
    bus.cmd_rd    = 2'(rd);
    bus.cmd_imm   = 4'(imm);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ld    = 1'b0;
    chk("ld_no_rsp", int'(bus.rsp_valid), 0);
    chk("ld_stay_idle", int'(bus.cmd_ready), 1);
    m_rf[rd] = imm;
  endtask

  task automatic do_op(input int op, input int rd, input int ra,
                       input int rb, input int stall,
                       output int gd, output int gf);
    int n;
    int ed;
    int ef;
    ref_alu(op, m_rf[ra], m_rf[rb], ed, ef);
    chk("op_ready", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_ld    = 1'b0;
    bus.cmd_op    = 3'(op);
    bus.cmd_rd    = 2'(rd);
    bus.cmd_ra    = 2'(ra);
    bus.cmd_rb    = 2'(rb);
    bus.rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("exec_s", int'(alu_s), op);
    chk("exec_a", int'(alu_a), m_rf[ra]);
    chk("exec_b", int'(alu_b), m_rf[rb]);
    chk("exec_busy", int'(bus.cmd_ready), 0);
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_latency", n, 1);
    gd = int'(bus.rsp_data);
    gf = int'(bus.rsp_flags);
    chk("rsp_data", gd, ed);
    chk("rsp_flags", gf, ef);
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_ld    = 1'b1;
        bus.cmd_rd    = 2'd0;
        bus.cmd_imm   = 4'd15;
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_ld    = 1'b0;
      chk("stall_valid", int'(bus.rsp_valid), 1);
      chk("stall_data", int'(bus.rsp_data), ed);
      chk("stall_flags", int'(bus.rsp_flags), ef);
      chk("stall_ready", int'(bus.cmd_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    m_rf[rd] = ed;
    m_cnt = (m_cnt + 1) % 256;
    chk("op_count", int'(op_count), m_cnt);
    chk("rsp_done", int'(bus.rsp_valid), 0);
  endtask

  initial begin
    int gd;
    int gf;
    int rose;
    bus.cmd_valid = 1'b0;
    bus.cmd_ld    = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_rd    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b0;

    tbl = '{
      '{1, 0, 0, 0, 0, 9, 0, 0},
      '{1, 0, 1, 0, 0, 8, 0, 0},
      '{0, 0, 2, 0, 1, 0, 1, 5},
      '{0, 3, 2, 2, 2, 0, 1, 1},
      '{1, 0, 0, 0, 0, 3, 0, 0},
      '{1, 0, 1, 0, 0, 5, 0, 0},
      '{0, 1, 3, 0, 1, 0, 14, 1},
      '{0, 3, 3, 3, 3, 0, 14, 1},
      '{1, 0, 0, 0, 0, 6, 0, 0},
      '{1, 0, 1, 0, 0, 6, 0, 0},
      '{0, 4, 0, 0, 1, 0, 0, 2},
      '{0, 3, 0, 0, 0, 0, 0, 2},
      '{0, 5, 1, 1, 0, 0, 9, 0},
      '{0, 6, 2, 1, 0, 0, 10, 0},
      '{0, 7, 3, 0, 0, 0, 15, 0},
      '{0, 2, 1, 1, 2, 0, 8, 1},
      '{0, 0, 0, 3, 3, 0, 14, 5}
    };

    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_s", int'(alu_s), 0);
    chk("rst_valid", int'(bus.rsp_valid), 0);
    do_reset();
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_count", int'(op_count), 0);
    chk("rst_data", int'(bus.rsp_data), 0);
    chk("rst_flags", int'(bus.rsp_flags), 0);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].ld != 0) begin
        do_ld(tbl[i].rd, tbl[i].imm);
      end else begin
        do_op(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, 0, gd, gf);
        chk("tbl_data", gd, tbl[i].ed);
        chk("tbl_flags", gf, tbl[i].ef);
      end
    end
    chk("tbl_count", int'(op_count), 11);

    // stalled response; the load pulsed meanwhile must be dropped
    do_op(0, 1, 0, 1, 5, gd, gf);
    chk("stall_sum", gd, 6);
    chk("stall_fl", gf, 4);
    do_op(3, 0, 0, 0, 0, gd, gf);
    chk("dropped_ld", gd, 14);

    do_ld(0, 7);
    do_ld(1, 4);
    bus.cmd_valid = 1'b1;
    bus.cmd_ld    = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_rd    = 2'd2;
    bus.cmd_ra    = 2'd0;
    bus.cmd_rb    = 2'd1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("abort_exec", int'(alu_s == 3'd0 && alu_a == 4'd7), 1);
    do_reset();
    chk("abort_ready", int'(bus.cmd_ready), 1);
    chk("abort_count", int'(op_count), 0);
    chk("abort_alu", int'(alu_a), 0);
    rose = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) rose = 1;
      @(posedge clk);
      #1;
    end
    chk("abort_no_rsp", rose, 0);
    do_op(3, 2, 2, 2, 0, gd, gf);
    chk("abort_r2", gd, 0);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(3) == 0)
        do_ld(int'($urandom_range(3)), int'($urandom_range(15)));
      do_op(int'($urandom_range(7)), int'($urandom_range(3)),
            int'($urandom_range(3)), int'($urandom_range(3)), 0, gd, gf);
      if (i == 254) chk("wrap_255", int'(op_count), 255);
      if (i == 255) chk("wrap_0", int'(op_count), 0);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
